// File: rtl/delay_line_var.sv
// rtl/delay_line_var.sv - valid/data delay line with runtime tap, stall and valid-only flush
module delay_line_var #(
    parameter int DATA_W    = 32,
    parameter int MAX_DELAY = 16,
    parameter int DELAY_W   = $clog2(MAX_DELAY + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic [DELAY_W-1:0] delay,
    input  logic               validIn,
    input  logic [DATA_W-1:0]  dataIn,
    output logic               validOut,
    output logic [DATA_W-1:0]  dataOut,
    output logic               busy
);

    localparam logic [DELAY_W-1:0] MAX_D = DELAY_W'(MAX_DELAY);

    logic [MAX_DELAY-1:0] v;
    logic [DATA_W-1:0]    d [MAX_DELAY];
    logic [DELAY_W-1:0]   deff;

    // Flush clears only the valid bits; the data shift follows en on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < MAX_DELAY; i++) begin
                d[i] <= '0;
            end
        end else begin
            if (en) begin
                d[0] <= dataIn;
                for (int i = 1; i < MAX_DELAY; i++) begin
                    d[i] <= d[i-1];
                end
            end
            if (flush) begin
                v <= '0;
            end else if (en) begin
                v[0] <= validIn;
                for (int i = 1; i < MAX_DELAY; i++) begin
                    v[i] <= v[i-1];
                end
            end
        end
    end

    assign deff = (delay > MAX_D) ? MAX_D : delay;

    // Tap select and busy both track the live delay value, so a delay change
    // moves the output and re-evaluates pending work in the same cycle.
    always_comb begin
        validOut = validIn;
        dataOut  = dataIn;
        busy     = 1'b0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (deff == DELAY_W'(i + 1)) begin
                validOut = v[i];
                dataOut  = d[i];
            end
            if (DELAY_W'(i) < deff) begin
                busy = busy | v[i];
            end
        end
    end

endmodule

// File: tb/tb_delay_line_var.sv
// tb/tb_delay_line_var.sv - directed self-checking bench for delay_line_var
module tb_delay_line_var;

    localparam int DATA_W    = 32;
    localparam int MAX_DELAY = 16;
    localparam int DELAY_W   = 5;

    logic               clk;
    logic               rst;
    logic               en;
    logic               flush;
    logic [DELAY_W-1:0] delay;
    logic               validIn;
    logic [DATA_W-1:0]  dataIn;
    logic               validOut;
    logic [DATA_W-1:0]  dataOut;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    delay_line_var #(
        .DATA_W   (DATA_W),
        .MAX_DELAY(MAX_DELAY),
        .DELAY_W  (DELAY_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .delay   (delay),
        .validIn (validIn),
        .dataIn  (dataIn),
        .validOut(validOut),
        .dataOut (dataOut),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; flush = 1'b0; validIn = 1'b0; dataIn = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_s;
        rst = 1'b0; en = 1'b0; flush = 1'b0; validIn = 1'b0; dataIn = '0;
        delay = 5'd4;

        // Reset state
        do_reset();
        #1;
        check("rst_valid", {31'b0, validOut}, 32'd0);
        check("rst_data", dataOut, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);

        // Fixed delay 4: sample e captured at edge e, shown after edge e+3
        for (int e = 1; e <= 26; e++) begin
            en = 1'b1;
            validIn = (e <= 20);
            dataIn  = (e <= 20) ? 32'(e) : 32'd0;
            tick();
            exp_s = e - 3;
            check("fix_valid", {31'b0, validOut}, {31'b0, (exp_s >= 1 && exp_s <= 20)});
            if (exp_s >= 1 && exp_s <= 20) check("fix_data", dataOut, 32'(exp_s));
        end

        // Bypass
        delay = 5'd0; en = 1'b0; validIn = 1'b1; dataIn = 32'h1234;
        #1;
        check("byp_data", dataOut, 32'h1234);
        check("byp_valid", {31'b0, validOut}, 32'd1);
        check("byp_busy", {31'b0, busy}, 32'd0);
        validIn = 1'b0; dataIn = 32'h55;
        #1;
        check("byp_data2", dataOut, 32'h55);
        check("byp_valid2", {31'b0, validOut}, 32'd0);

        // Clamp: delay 31 behaves as 16
        do_reset();
        delay = 5'd31; en = 1'b1; validIn = 1'b1; dataIn = 32'hA5;
        tick();
        validIn = 1'b0; dataIn = '0;
        for (int e = 2; e <= 17; e++) begin
            tick();
            check("clamp_valid", {31'b0, validOut}, {31'b0, (e == 16)});
            if (e == 16) check("clamp_data", dataOut, 32'hA5);
            check("clamp_busy", {31'b0, busy}, {31'b0, (e <= 16)});
        end

        // Stall
        do_reset();
        delay = 5'd3; en = 1'b1; validIn = 1'b1;
        dataIn = 32'h11; tick();
        dataIn = 32'h22; tick();
        dataIn = 32'h33; tick();
        check("stall_pre", dataOut, 32'h11);
        en = 1'b0; dataIn = 32'hFF;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall_hold_v", {31'b0, validOut}, 32'd1);
            check("stall_hold_d", dataOut, 32'h11);
        end
        en = 1'b1; validIn = 1'b0; dataIn = '0;
        tick(); check("stall_d22", dataOut, 32'h22);
        tick(); check("stall_d33", dataOut, 32'h33);
        check("stall_v33", {31'b0, validOut}, 32'd1);
        tick(); check("stall_end", {31'b0, validOut}, 32'd0);

        // Flush
        do_reset();
        delay = 5'd8; en = 1'b1; validIn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            dataIn = 32'h61 + 32'(k);
            tick();
        end
        check("fl_busy_pre", {31'b0, busy}, 32'd1);
        flush = 1'b1; dataIn = 32'h99;
        tick();
        flush = 1'b0; validIn = 1'b0; dataIn = '0;
        check("fl_busy", {31'b0, busy}, 32'd0);
        check("fl_valid", {31'b0, validOut}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("fl_idle", {31'b0, validOut | busy}, 32'd0);
        end
        validIn = 1'b1; dataIn = 32'h77;
        tick();
        validIn = 1'b0; dataIn = '0;
        for (int k = 2; k <= 8; k++) begin
            check("fl_post_early", {31'b0, validOut}, 32'd0);
            tick();
        end
        check("fl_post_v", {31'b0, validOut}, 32'd1);
        check("fl_post_d", dataOut, 32'h77);

        // Runtime delay change 6 -> 2 after sample 5
        do_reset();
        delay = 5'd6; en = 1'b1; validIn = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            dataIn = 32'(e);
            tick();
        end
        check("chg_pre_v", {31'b0, validOut}, 32'd0);
        check("chg_pre_busy", {31'b0, busy}, 32'd1);
        delay = 5'd2;
        #1;
        check("chg_now_v", {31'b0, validOut}, 32'd1);
        check("chg_now_d", dataOut, 32'd4);
        check("chg_now_busy", {31'b0, busy}, 32'd1);
        for (int e = 6; e <= 12; e++) begin
            validIn = (e <= 10);
            dataIn  = (e <= 10) ? 32'(e) : 32'd0;
            tick();
            check("chg_v", {31'b0, validOut}, {31'b0, (e <= 11)});
            if (e <= 11) check("chg_d", dataOut, 32'(e - 1));
        end

        // Reset mid-stream
        do_reset();
        delay = 5'd5; en = 1'b1; validIn = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            dataIn = 32'h100 + 32'(e);
            tick();
        end
        rst = 1'b1; dataIn = 32'h1FF;
        tick();
        rst = 1'b0; validIn = 1'b0; dataIn = '0;
        check("mrst_valid", {31'b0, validOut}, 32'd0);
        check("mrst_data", dataOut, 32'd0);
        check("mrst_busy", {31'b0, busy}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("mrst_drain_v", {31'b0, validOut}, 32'd0);
            check("mrst_drain_d", dataOut, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_line_var.md
# delay_line_var

Parametrised successor to the fixed-depth register delay chain: a `{valid, data}` pipeline of up to MAX_DELAY stages with a runtime-selectable tap, a stall enable and a valid-only flush. It sits between datapath stages whose relative latency is known only at run time, for example when realigning distance results against labels in the KNN datapath. It adds a pending-work indicator for the surrounding control FSM.

## Interface
- DATA_W, 32: payload width.
- MAX_DELAY, 16: number of stages; legal range 1..256.
- DELAY_W, $clog2(MAX_DELAY+1): width of the delay select.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high; highest priority.
- en  input  1  advance enable; 0 freezes every stage.
- flush  input  1  synchronous clear of all valid bits; data bits are untouched.
- delay  input  DELAY_W  runtime tap select; values above MAX_DELAY are clamped to MAX_DELAY.
- validIn  input  1  qualifier for dataIn.
- dataIn  input  DATA_W  payload.
- validOut  output  1  valid bit at the selected tap.
- dataOut  output  DATA_W  payload at the selected tap.
- busy  output  1  1 when any stage 0..Deff-1 holds valid=1.

## Operation
- Storage: stages s[0..MAX_DELAY-1], each holding `{v, d}`.
- On a rising edge with rst=1:
  - every s[i].v and s[i].d becomes 0;
  - en, flush and validIn are ignored.
- On a rising edge with rst=0 and flush=1:
  - every s[i].v becomes 0, regardless of en;
  - data bits shift if en=1 and hold if en=0;
  - validIn in this cycle is discarded.
- On a rising edge with rst=0, flush=0 and en=1:
  - s[0] captures `{validIn, dataIn}`;
  - s[i] captures s[i-1] for i=1..MAX_DELAY-1;
  - the contents of s[MAX_DELAY-1] are dropped.
- On a rising edge with rst=0, flush=0 and en=0: all stages hold.
- Effective delay Deff = min(delay, MAX_DELAY).
- Output tap:
  - Deff=0: pure combinational bypass. dataOut=dataIn and validOut=validIn, regardless of en.
  - Deff≥1: `{validOut, dataOut}` = s[Deff-1], selected combinationally from the current delay value.
- Changing delay mid-stream:
  - the tap moves immediately, with no drain or refill;
  - entries beyond the new tap are skipped;
  - entries already shown may be shown again;
  - the consumer must qualify output with validOut and change delay only when busy=0 or when losing or duplicating entries is acceptable.
- busy is combinational:
  - OR of s[0..Deff-1].v;
  - 0 when Deff=0.
- The block has no backpressure output; en is the only flow control.

## Timing
- Reset values: validOut=0, dataOut=0, busy=0. Exception: with Deff=0, validOut and dataOut follow validIn and dataIn.
- Latency with en held at 1 and Deff=D≥1:
  - a sample presented in the cycle before edge k appears on dataOut after edge k+D-1, i.e. D edges after capture;
  - throughput is one sample per cycle.
- With en gaps, latency equals D edges at which en=1.
- During stall, outputs stay constant unless delay changes.
- Priority order: rst > flush > en.
- flush and rst each take effect on the edge they are sampled. The following cycle shows validOut=0 and busy=0 when Deff≥1.
- rst asserted mid-stream: all in-flight samples are lost. No output glitch other than the combinational bypass path.

## Test plan
- Fixed delay: MAX_DELAY=16, delay=4, en=1. Drive validIn=1 and dataIn=1..20 on consecutive cycles. Expect validOut first high 4 edges after dataIn=1 is captured, then 1..20 in order with no gaps, then validOut=0.
- Bypass and clamp:
  - delay=0: dataOut equals dataIn in the same cycle.
  - delay=31 (with DELAY_W=5): behaves exactly as delay=16, i.e. 0xA5 emerges 16 edges after capture.
- Stall: delay=3, send 0x11, 0x22, 0x33, then deassert en for 5 cycles with validIn=1 and dataIn=0xFF.
  - Outputs hold during the stall.
  - After en returns, the sequence is 0x11, 0x22, 0x33 with no 0xFF injected.
- Flush: delay=8, six valid samples in flight, then assert flush for one cycle with en=1 and validIn=1. Expect busy=0 next cycle and validOut=0 for the next 8 edges. Samples sent after the flush emerge normally.
- Runtime delay change: stream 1..10 at delay=6, switch to delay=2 after sample 5 is captured. Expect immediate output of s[1] (sample 4), then 5, 6, 7…. busy recomputed against the new Deff the same cycle.
- Reset mid-stream: delay=5, stream running, assert rst for 1 cycle with en=1. Expect validOut=0, dataOut=0 and busy=0 after the edge, and no pre-reset sample ever emerges.
